// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory-stage load/store/atomic unit with a simple req/gnt bus
//
// Accepts one memory operation from the pipeline's memory stage. It drives a
// request onto a lane-based bus, collects the read response, extends the
// loaded value, and pulses done_M when the operation retires. Misaligned
// accesses and unsupported atomics are rejected with a one-cycle fault pulse
// and never reach the bus.
//
// Configuration macro: MEM_ACCESS_ATOMIC_EN
//   defined   : atomic read-modify-write path present (AMO_WR state); amoOp_M
//               codes 101..111 raise illegal_M.
//   undefined : no atomic path; any amo_M request raises illegal_M.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_M             memory-stage operation present
//   memRead_M/memWrite_M/amo_M   load / store / atomic (one-hot or none)
//   size_M              00 byte, 01 half, 10 word, 11 double
//   unsigned_M          zero-extend (1) or sign-extend (0) load data
//   amoOp_M             000 swap, 001 add, 010 and, 011 or, 100 xor
//   aluResult_M         byte address
//   writeData_M         store / AMO source operand
//   stall_M             hold upstream pipeline registers
//   readData_M          extended load data or AMO old value (valid with done_M)
//   done_M              one-cycle retire pulse
//   misaligned_M        one-cycle misalignment fault pulse
//   illegal_M           one-cycle unsupported-operation fault pulse
//   bus_req, bus_we     bus request / write enable
//   bus_addr            address aligned down to the bus width
//   bus_wdata, bus_wstrb lane-shifted write data and byte strobes
//   bus_gnt             bus accepts the request this cycle
//   bus_rvalid, bus_rdata read response
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_M,
    input  logic           memRead_M,
    input  logic           memWrite_M,
    input  logic           amo_M,
    input  logic [1:0]     size_M,
    input  logic           unsigned_M,
    input  logic [2:0]     amoOp_M,
    input  logic [N-1:0]   aluResult_M,
    input  logic [N-1:0]   writeData_M,
    output logic           stall_M,
    output logic [N-1:0]   readData_M,
    output logic           done_M,
    output logic           misaligned_M,
    output logic           illegal_M,
    output logic           bus_req,
    output logic           bus_we,
    output logic [N-1:0]   bus_addr,
    output logic [N-1:0]   bus_wdata,
    output logic [N/8-1:0] bus_wstrb,
    input  logic           bus_gnt,
    input  logic           bus_rvalid,
    input  logic [N-1:0]   bus_rdata
);

    localparam int LANES = N / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
`ifdef MEM_ACCESS_ATOMIC_EN
        ST_WR_REQ  = 3'd3,
        ST_AMO_WR  = 3'd4
`else
        ST_WR_REQ  = 3'd3
`endif
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // Mask of the low bits that belong to an access of the given size.
    function automatic logic [N-1:0] size_mask(input logic [1:0] size);
        logic [N-1:0] m;
        case (size)
            2'b00:   m = {{(N-8){1'b0}}, 8'hFF};
            2'b01:   m = {{(N-16){1'b0}}, 16'hFFFF};
            2'b10:   m = {{(N-32){1'b0}}, 32'hFFFF_FFFF};
            default: m = {N{1'b1}};
        endcase
        return m;
    endfunction

    // Address low bits that must be zero for a naturally aligned access.
    function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] size);
        logic [OFF_W-1:0] m;
        m = {OFF_W{1'b0}};
        case (size)
            2'b00:   m = {OFF_W{1'b0}};
            2'b01:   m[0] = 1'b1;
            2'b10:   m[1:0] = 2'b11;
            default: m[2:0] = 3'b111;
        endcase
        return m;
    endfunction

    // Byte strobes: 2^size contiguous lanes starting at the byte offset.
    function automatic logic [LANES-1:0] lane_strb(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] off);
        logic [LANES-1:0] s;
        case (size)
            2'b00:   s = {{(LANES-1){1'b0}}, 1'b1};
            2'b01:   s = {{(LANES-2){1'b0}}, 2'b11};
            2'b10:   s = {{(LANES-4){1'b0}}, 4'hF};
            default: s = {LANES{1'b1}};
        endcase
        return s << off;
    endfunction

    // Trim the operand to the access size and move it onto its byte lanes.
    function automatic logic [N-1:0] lane_data(input logic [N-1:0] data,
                                               input logic [1:0] size,
                                               input logic [OFF_W-1:0] off);
        return (data & size_mask(size)) << {off, 3'b000};
    endfunction

    // Pull the addressed lanes down to bit 0 and sign/zero extend.
    function automatic logic [N-1:0] extract(input logic [N-1:0] rdata,
                                             input logic [1:0] size,
                                             input logic [OFF_W-1:0] off,
                                             input logic uns);
        logic [N-1:0] raw;
        logic [N-1:0] e;
        logic         sgn;
        raw = rdata >> {off, 3'b000};
        sgn = ~uns;
        case (size)
            2'b00:   e = {{(N-8){raw[7] & sgn}}, raw[7:0]};
            2'b01:   e = {{(N-16){raw[15] & sgn}}, raw[15:0]};
            2'b10:   e = {{(N-32){raw[31] & sgn}}, raw[31:0]};
            default: e = raw;
        endcase
        return e;
    endfunction

`ifdef MEM_ACCESS_ATOMIC_EN
    // Atomic update; masking to the access size gives word ops their mod-2^32 wrap.
    function automatic logic [N-1:0] amo_calc(input logic [2:0] op,
                                              input logic [N-1:0] old_v,
                                              input logic [N-1:0] src,
                                              input logic [1:0] size);
        logic [N-1:0] r;
        case (op)
            3'b000:  r = src;
            3'b001:  r = old_v + src;
            3'b010:  r = old_v & src;
            3'b011:  r = old_v | src;
            3'b100:  r = old_v ^ src;
            default: r = src;
        endcase
        return r & size_mask(size);
    endfunction
`endif

    // -----------------------------------------------------------------------
    // State and latched operands
    // -----------------------------------------------------------------------
    state_t           r_state, w_state_n;
    logic [N-1:0]     r_addr, w_addr_n;
    logic [N-1:0]     r_wdata, w_wdata_n;
    logic [1:0]       r_size, w_size_n;
    logic             r_uns, w_uns_n;
`ifdef MEM_ACCESS_ATOMIC_EN
    logic [2:0]       r_op, w_op_n;
    logic             r_is_amo, w_is_amo_n;
`endif
    logic [N-1:0]     r_read_data, w_read_data_n;
    logic             r_done, w_done_n;
    logic             r_misal, w_misal_n;
    logic             r_illegal, w_illegal_n;
    logic             r_bus_req, w_bus_req_n;
    logic             r_bus_we, w_bus_we_n;
    logic [N-1:0]     r_bus_addr, w_bus_addr_n;
    logic [N-1:0]     r_bus_wdata, w_bus_wdata_n;
    logic [LANES-1:0] r_bus_wstrb, w_bus_wstrb_n;

    // -----------------------------------------------------------------------
    // Request decode in IDLE
    // -----------------------------------------------------------------------
    logic             w_any_op;
    logic             w_block;
    logic             w_take;
    logic             w_nop;
    logic             w_illegal_op;
    logic             w_misal_op;
    logic [OFF_W-1:0] w_off;
    logic [N-1:0]     w_aligned;
    logic [OFF_W-1:0] w_r_off;
    logic [N-1:0]     w_raw_lane;

    assign w_any_op  = memRead_M | memWrite_M | amo_M;
    // The cycle carrying a done/fault pulse still shows the retiring operation
    // on the inputs (the pipeline advances at its end), so it must not restart.
    assign w_block   = r_done | r_misal | r_illegal;
    assign w_take    = (r_state == ST_IDLE) & valid_M & w_any_op & ~w_block;
    assign w_nop     = (r_state == ST_IDLE) & valid_M & ~w_any_op & ~w_block;
    assign w_off     = aluResult_M[OFF_W-1:0];
    assign w_aligned = {aluResult_M[N-1:OFF_W], {OFF_W{1'b0}}};
    assign w_r_off   = r_addr[OFF_W-1:0];
    assign w_raw_lane = bus_rdata >> {w_r_off, 3'b000};

`ifdef MEM_ACCESS_ATOMIC_EN
    assign w_illegal_op = amo_M & (amoOp_M > 3'b100);
    assign w_misal_op   = (|(w_off & align_mask(size_M))) | (amo_M & ~size_M[1]);
`else
    logic w_unused_amo;
    assign w_unused_amo = ^{amoOp_M, w_raw_lane};
    assign w_illegal_op = amo_M;
    assign w_misal_op   = |(w_off & align_mask(size_M));
`endif

    // Next-state and next-output logic of the access FSM.
    always_comb begin
        w_state_n     = r_state;
        w_addr_n      = r_addr;
        w_wdata_n     = r_wdata;
        w_size_n      = r_size;
        w_uns_n       = r_uns;
`ifdef MEM_ACCESS_ATOMIC_EN
        w_op_n        = r_op;
        w_is_amo_n    = r_is_amo;
`endif
        w_read_data_n = r_read_data;
        w_done_n      = 1'b0;
        w_misal_n     = 1'b0;
        w_illegal_n   = 1'b0;
        w_bus_req_n   = r_bus_req;
        w_bus_we_n    = r_bus_we;
        w_bus_addr_n  = r_bus_addr;
        w_bus_wdata_n = r_bus_wdata;
        w_bus_wstrb_n = r_bus_wstrb;

        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    if (w_illegal_op) begin
                        w_illegal_n = 1'b1;
                    end else if (w_misal_op) begin
                        w_misal_n = 1'b1;
                    end else begin
                        w_addr_n     = aluResult_M;
                        w_wdata_n    = writeData_M;
                        w_size_n     = size_M;
                        w_uns_n      = unsigned_M;
`ifdef MEM_ACCESS_ATOMIC_EN
                        w_op_n       = amoOp_M;
                        w_is_amo_n   = amo_M;
`endif
                        w_bus_req_n  = 1'b1;
                        w_bus_addr_n = w_aligned;
                        if (memWrite_M) begin
                            w_state_n     = ST_WR_REQ;
                            w_bus_we_n    = 1'b1;
                            w_bus_wstrb_n = lane_strb(size_M, w_off);
                            w_bus_wdata_n = lane_data(writeData_M, size_M, w_off);
                        end else begin
                            // Loads and atomics both start with a read.
                            w_state_n     = ST_RD_REQ;
                            w_bus_we_n    = 1'b0;
                            w_bus_wstrb_n = {LANES{1'b0}};
                            w_bus_wdata_n = {N{1'b0}};
                        end
                    end
                end else begin
                    w_state_n = ST_IDLE;
                end
            end

            ST_RD_REQ: begin
                if (bus_gnt) begin
                    w_state_n   = ST_RD_WAIT;
                    w_bus_req_n = 1'b0;
                end else begin
                    w_state_n = ST_RD_REQ;
                end
            end

            ST_RD_WAIT: begin
                if (bus_rvalid) begin
                    w_read_data_n = extract(bus_rdata, r_size, w_r_off, r_uns);
`ifdef MEM_ACCESS_ATOMIC_EN
                    if (r_is_amo) begin
                        w_state_n     = ST_AMO_WR;
                        w_bus_req_n   = 1'b1;
                        w_bus_we_n    = 1'b1;
                        w_bus_addr_n  = {r_addr[N-1:OFF_W], {OFF_W{1'b0}}};
                        w_bus_wstrb_n = lane_strb(r_size, w_r_off);
                        w_bus_wdata_n = lane_data(amo_calc(r_op, w_raw_lane, r_wdata, r_size),
                                                  r_size, w_r_off);
                    end else begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end
`else
                    w_state_n = ST_IDLE;
                    w_done_n  = 1'b1;
`endif
                end else begin
                    w_state_n = ST_RD_WAIT;
                end
            end

`ifdef MEM_ACCESS_ATOMIC_EN
            ST_AMO_WR,
`endif
            ST_WR_REQ: begin
                if (bus_gnt) begin
                    w_state_n     = ST_IDLE;
                    w_done_n      = 1'b1;
                    w_bus_req_n   = 1'b0;
                    w_bus_we_n    = 1'b0;
                    w_bus_addr_n  = {N{1'b0}};
                    w_bus_wdata_n = {N{1'b0}};
                    w_bus_wstrb_n = {LANES{1'b0}};
                end else begin
                    w_state_n = r_state;
                end
            end

            default: begin
                w_state_n     = ST_IDLE;
                w_bus_req_n   = 1'b0;
                w_bus_we_n    = 1'b0;
                w_bus_addr_n  = {N{1'b0}};
                w_bus_wdata_n = {N{1'b0}};
                w_bus_wstrb_n = {LANES{1'b0}};
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= {N{1'b0}};
            r_wdata     <= {N{1'b0}};
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
`ifdef MEM_ACCESS_ATOMIC_EN
            r_op        <= 3'b000;
            r_is_amo    <= 1'b0;
`endif
            r_read_data <= {N{1'b0}};
            r_done      <= 1'b0;
            r_misal     <= 1'b0;
            r_illegal   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= {N{1'b0}};
            r_bus_wdata <= {N{1'b0}};
            r_bus_wstrb <= {LANES{1'b0}};
        end else begin
            r_state     <= w_state_n;
            r_addr      <= w_addr_n;
            r_wdata     <= w_wdata_n;
            r_size      <= w_size_n;
            r_uns       <= w_uns_n;
`ifdef MEM_ACCESS_ATOMIC_EN
            r_op        <= w_op_n;
            r_is_amo    <= w_is_amo_n;
`endif
            r_read_data <= w_read_data_n;
            r_done      <= w_done_n;
            r_misal     <= w_misal_n;
            r_illegal   <= w_illegal_n;
            r_bus_req   <= w_bus_req_n;
            r_bus_we    <= w_bus_we_n;
            r_bus_addr  <= w_bus_addr_n;
            r_bus_wdata <= w_bus_wdata_n;
            r_bus_wstrb <= w_bus_wstrb_n;
        end
    end

    // A valid cycle with no memory operation retires immediately; everything
    // else retires from the registered pulse.
    assign done_M       = r_done | w_nop;
    assign stall_M      = (r_state != ST_IDLE) | w_take;
    assign readData_M   = r_read_data;
    assign misaligned_M = r_misal;
    assign illegal_M    = r_illegal;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_wstrb    = r_bus_wstrb;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access (N = 64).
// Directed cases for the documented examples plus randomized operations,
// all compared against a reference model written with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_access;
    localparam int N = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_M = 1'b0;
    logic          memRead_M = 1'b0;
    logic          memWrite_M = 1'b0;
    logic          amo_M = 1'b0;
    logic [1:0]    size_M = 2'b00;
    logic          unsigned_M = 1'b0;
    logic [2:0]    amoOp_M = 3'b000;
    logic [N-1:0]  aluResult_M = '0;
    logic [N-1:0]  writeData_M = '0;
    logic          stall_M;
    logic [N-1:0]  readData_M;
    logic          done_M;
    logic          misaligned_M;
    logic          illegal_M;
    logic          bus_req;
    logic          bus_we;
    logic [N-1:0]  bus_addr;
    logic [N-1:0]  bus_wdata;
    logic [N/8-1:0] bus_wstrb;
    logic          bus_gnt = 1'b0;
    logic          bus_rvalid = 1'b0;
    logic [N-1:0]  bus_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit seen;

    mem_access #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .memRead_M(memRead_M),
        .memWrite_M(memWrite_M), .amo_M(amo_M), .size_M(size_M),
        .unsigned_M(unsigned_M), .amoOp_M(amoOp_M), .aluResult_M(aluResult_M),
        .writeData_M(writeData_M), .stall_M(stall_M), .readData_M(readData_M),
        .done_M(done_M), .misaligned_M(misaligned_M), .illegal_M(illegal_M),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_mask(input int size);
        if (size == 3) return 64'hFFFF_FFFF_FFFF_FFFF;
        return (64'd1 << (8 << size)) - 64'd1;
    endfunction

    function automatic logic [63:0] m_lane(input logic [63:0] rd, input logic [63:0] addr, input int size);
        return (rd >> (8 * (addr % 8))) & m_mask(size);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [63:0] addr,
                                           input int size, input bit uns);
        logic [63:0] v;
        v = m_lane(rd, addr, size);
        if (!uns && (((v >> ((8 << size) - 1)) & 64'd1) == 64'd1)) v = v | ~m_mask(size);
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input logic [63:0] addr, input int size);
        logic [63:0] t;
        t = ((64'd1 << (1 << size)) - 64'd1) << (addr % 8);
        return t[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [63:0] addr, input int size);
        return (d & m_mask(size)) << (8 * (addr % 8));
    endfunction

    function automatic logic [63:0] m_amo(input int op, input logic [63:0] old_v,
                                          input logic [63:0] src, input int size);
        logic [63:0] r;
        case (op)
            0:       r = src;
            1:       r = old_v + src;
            2:       r = old_v & src;
            3:       r = old_v | src;
            4:       r = old_v ^ src;
            default: r = src;
        endcase
        return r & m_mask(size);
    endfunction

    // 0 none, 1 misaligned, 2 illegal
    function automatic int m_fault(input int kind, input logic [63:0] addr, input int size, input int op);
        bit mis;
        mis = (addr % (64'd1 << size)) != 64'd0;
`ifdef MEM_ACCESS_ATOMIC_EN
        if (kind == 2 && op > 4) return 2;
        if (kind == 2 && size < 2) return 1;
`else
        if (kind == 2) return 2;
`endif
        if (kind != 3 && mis) return 1;
        return 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic scramble();
        valid_M     = 1'b0;
        memRead_M   = $urandom_range(0, 1);
        memWrite_M  = $urandom_range(0, 1);
        amo_M       = $urandom_range(0, 1);
        size_M      = 2'($urandom_range(0, 3));
        unsigned_M  = $urandom_range(0, 1);
        amoOp_M     = 3'($urandom_range(0, 7));
        aluResult_M = {$urandom, $urandom};
        writeData_M = {$urandom, $urandom};
    endtask

    // Holds the request for gd cycles, then grants; checks stability every cycle.
    task automatic req_phase(input string tag, input logic [63:0] a, input logic we,
                             input bit chk_data, input logic [7:0] st,
                             input logic [63:0] wdat, input int gd);
        for (int k = 0; k <= gd; k++) begin
            #1;
            chk_val({tag, "_req"}, bus_req, 1'b1);
            chk_val({tag, "_addr"}, bus_addr, a);
            chk_val({tag, "_we"}, bus_we, we);
            if (chk_data) begin
                chk_val({tag, "_strb"}, bus_wstrb, st);
                chk_val({tag, "_wdata"}, bus_wdata, wdat);
            end
            bus_gnt = (k == gd);
            @(negedge clk);
        end
        bus_gnt = 1'b0;
    endtask

    // kind: 0 load, 1 store, 2 amo, 3 no memory op
    task automatic run_op(input int kind, input logic [63:0] addr, input int size, input bit uns,
                          input int op, input logic [63:0] wd, input logic [63:0] rd,
                          input int gd1, input int rvd, input int gd2);
        int          fault;
        int          start;
        int          exp_lat;
        bit          got;
        logic [63:0] al;
        fault = m_fault(kind, addr, size, op);
        al    = addr & ~64'h7;
        @(negedge clk);
        valid_M     = 1'b1;
        memRead_M   = (kind == 0);
        memWrite_M  = (kind == 1);
        amo_M       = (kind == 2);
        size_M      = 2'(size);
        unsigned_M  = uns;
        amoOp_M     = 3'(op);
        aluResult_M = addr;
        writeData_M = wd;
        #1;
        start = cyc;
        if (kind == 3) begin
            chk_val("nop_done", done_M, 1'b1);
            chk_val("nop_stall", stall_M, 1'b0);
            @(negedge clk);
            valid_M = 1'b0;
            #1;
            chk_val("nop_pulse", done_M, 1'b0);
            return;
        end
        chk_val("acc_stall", stall_M, 1'b1);
        @(negedge clk);
        scramble();
        if (fault != 0) begin
            #1;
            chk_val("flt_misal", misaligned_M, fault == 1);
            chk_val("flt_illegal", illegal_M, fault == 2);
            chk_val("flt_busreq", bus_req, 1'b0);
            chk_val("flt_done", done_M, 1'b0);
            chk_val("flt_stall", stall_M, 1'b0);
            @(negedge clk);
            #1;
            chk_val("flt_clear", {misaligned_M, illegal_M, bus_req}, 3'b000);
            return;
        end
        if (kind == 1) begin
            req_phase("st", al, 1'b1, 1'b1, m_strb(addr, size), m_wdata(wd, addr, size), gd1);
            exp_lat = 2 + gd1;
        end else begin
            req_phase("rd", al, 1'b0, 1'b0, 8'h00, 64'h0, gd1);
            for (int k = 0; k < rvd; k++) begin
                #1;
                chk_val("rdw_noreq", bus_req, 1'b0);
                @(negedge clk);
            end
            #1;
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
            @(negedge clk);
            bus_rvalid = 1'b0;
            bus_rdata  = {$urandom, $urandom};
            exp_lat = 3 + gd1 + rvd;
            if (kind == 2) begin
                req_phase("amo", al, 1'b1, 1'b1, m_strb(addr, size),
                          m_wdata(m_amo(op, m_lane(rd, addr, size), wd, size), addr, size), gd2);
                exp_lat = exp_lat + 1 + gd2;
            end
        end
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (done_M) got = 1'b1;
            else @(negedge clk);
        end
        chk_val("done_seen", got, 1'b1);
        if (got) begin
            chk_val("latency", cyc - start, exp_lat);
            chk_val("done_stall", stall_M, 1'b0);
            if (kind != 1) chk_val("read_data", readData_M, m_load(rd, addr, size, uns));
            @(negedge clk);
            #1;
            chk_val("done_pulse", done_M, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, size, op;
        logic [63:0] addr;

        // Reset state
        #1;
        chk_val("rst_outs", {bus_req, done_M, stall_M, misaligned_M, illegal_M, bus_we}, 6'b0);
        chk_val("rst_rdata", readData_M, 64'h0);
        chk_val("rst_strb", bus_wstrb, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Signed byte load with immediate bus; done three cycles after accept
        run_op(0, 64'h1003, 0, 1'b0, 0, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0);
        chk_val("ex_lb_value", readData_M, 64'hFFFF_FFFF_FFFF_FF80);
        // Half store with a delayed grant
        run_op(1, 64'h2006, 1, 1'b0, 0, 64'h0000_0000_0000_ABCD, 64'h0, 4, 0, 0);
        // Misaligned word load
        run_op(0, 64'h1002, 2, 1'b0, 0, 64'h0, 64'h0, 0, 0, 0);
        // No memory op retires in the same cycle
        run_op(3, 64'h0, 0, 1'b0, 0, 64'h0, 64'h0, 0, 0, 0);
`ifdef MEM_ACCESS_ATOMIC_EN
        run_op(2, 64'h3000, 2, 1'b0, 1, 64'h1, 64'h0000_0000_7FFF_FFFF, 0, 0, 0);
        chk_val("ex_amo_old", readData_M, 64'h0000_0000_7FFF_FFFF);
        run_op(2, 64'h3000, 3, 1'b0, 5, 64'h1, 64'h0, 0, 0, 0);
`else
        run_op(2, 64'h3000, 2, 1'b0, 1, 64'h1, 64'h0000_0000_7FFF_FFFF, 0, 0, 0);
`endif

        // Reset while waiting for read data, then a stale response
        @(negedge clk);
        valid_M = 1'b1; memRead_M = 1'b1; memWrite_M = 1'b0; amo_M = 1'b0;
        size_M = 2'b11; aluResult_M = 64'h1000;
        @(negedge clk);
        scramble();
        req_phase("rst", 64'h1000, 1'b0, 1'b0, 8'h00, 64'h0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("rst_mid_outs", {bus_req, stall_M, done_M}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        bus_rvalid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (done_M || bus_req) seen = 1'b1;
            @(negedge clk);
        end
        chk_val("rst_no_done", seen, 1'b0);
        chk_val("rst_rdata_clr", readData_M, 64'h0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            size = $urandom_range(0, 3);
            if (kind == 2 && $urandom_range(0, 3) != 0) size = 2 + $urandom_range(0, 1);
            op = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
            run_op(kind, addr, size, $urandom_range(0, 1), op, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
